// File: rtl/hmmm_pkg.sv
// Shared definitions for the Hmmm RAM stage.
// Contents: default address/data widths, the RAM FSM state encoding,
// the largest legal wait-state count, and the width of the wait counter.
package hmmm_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } ram_state_t;

endpackage

// File: rtl/ram_unit_array.sv
// ram_array: 2^ADDR_W x DATA_W word storage, no reset.
// One synchronous write port and one combinational read port.
// When HMMM_RAM_LOADER_EN is defined a second synchronous write port
// (ld_*) is added for program preload; it takes priority over the main
// write port when both hit the same address on the same edge.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address
//   rd_data  out  array[raddr], combinational
//   ld_en/ld_addr/ld_data  in  preload port (HMMM_RAM_LOADER_EN only)
module ram_array
  import hmmm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data
`ifdef HMMM_RAM_LOADER_EN
  ,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`endif
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
`ifdef HMMM_RAM_LOADER_EN
    // Later assignment wins on an address collision: the load has priority.
    if (ld_en) mem[ld_addr] <= ld_data;
`endif
  end

  assign rd_data = mem[raddr];

endmodule

// File: rtl/ram_unit.sv
// ram_unit: main-memory stage of the Hmmm datapath.
// Accepts one-cycle read/write requests in IDLE, latches address/op/data,
// waits WAIT_CYCLES states, performs the access, then pulses done.
// Read data lands in the MDR, which is gated onto bus_out by mdr_out.
// Optional build macro: HMMM_RAM_LOADER_EN adds a preload port.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   ram_address  in   word address (from MAR)
//   rd_req       in   read request, honoured only in IDLE
//   wr_req       in   write request, honoured only in IDLE (wins over rd_req)
//   bus_in       in   write data
//   mdr_out      in   drive MDR onto bus_out
//   bus_out      out  MDR when mdr_out, else 0
//   busy         out  high outside IDLE
//   done         out  one-cycle completion pulse
//   load_en/load_addr/load_data  in  preload (HMMM_RAM_LOADER_EN only)
module ram_unit
  import hmmm_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done
`ifdef HMMM_RAM_LOADER_EN
  ,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  ram_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              arr_we;

`ifdef HMMM_RAM_LOADER_EN
  assign accept = (rd_req | wr_req) & ~load_en;
`else
  assign accept = rd_req | wr_req;
`endif

  // Gate with rst so a write whose ACCESS edge coincides with reset is dropped.
  assign arr_we = (state == S_ACCESS) & req_wr & ~rst;

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .waddr   (req_addr),
    .wdata   (req_data),
    .raddr   (req_addr),
    .rd_data (rd_data)
`ifdef HMMM_RAM_LOADER_EN
    ,
    .ld_en   (load_en),
    .ld_addr (load_addr),
    .ld_data (load_data)
`endif
  );

  // Request registers are not reset: they are only consumed after a
  // request has loaded them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      mdr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_addr <= ram_address;
            req_wr   <= wr_req;
            req_data <= bus_in;
            busy     <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_ACCESS;
          else           cnt   <= cnt - 1'b1;
        end
        S_ACCESS: begin
          if (!req_wr) mdr <= rd_data;
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_out = mdr_out ? mdr : '0;

endmodule

// File: tb/tb_ram_unit.sv
// Directed bench for ram_unit. Main instance uses WAIT_CYCLES=1; two shadow
// instances (WAIT_CYCLES=0 and 4) share the same inputs so latency can be
// compared across configurations in one run.
module tb_ram_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ram_address;
  logic        rd_req, wr_req, mdr_out;
  logic [15:0] bus_in;
  logic [15:0] bus_out_m, bus_out_0, bus_out_4;
  logic        busy_m, busy_0, busy_4;
  logic        done_m, done_0, done_4;
`ifdef HMMM_RAM_LOADER_EN
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
`endif

  int checks = 0;
  int failures = 0;
  int lat_m, lat_0, lat_4, ndone;
  logic busy_rst;

  always #5 clk = ~clk;

  ram_unit #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .ram_address(ram_address), .rd_req(rd_req),
    .wr_req(wr_req), .bus_in(bus_in), .mdr_out(mdr_out),
    .bus_out(bus_out_m), .busy(busy_m), .done(done_m)
`ifdef HMMM_RAM_LOADER_EN
    , .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`endif
  );

  ram_unit #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .ram_address(ram_address), .rd_req(rd_req),
    .wr_req(wr_req), .bus_in(bus_in), .mdr_out(mdr_out),
    .bus_out(bus_out_0), .busy(busy_0), .done(done_0)
`ifdef HMMM_RAM_LOADER_EN
    , .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`endif
  );

  ram_unit #(.WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst), .ram_address(ram_address), .rd_req(rd_req),
    .wr_req(wr_req), .bus_in(bus_in), .mdr_out(mdr_out),
    .bus_out(bus_out_4), .busy(busy_4), .done(done_4)
`ifdef HMMM_RAM_LOADER_EN
    , .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare bus_out with mdr_out high (MDR value) and low (zero).
  task automatic chk_mdr(input string tag, input logic [15:0] exp);
    @(negedge clk);
    mdr_out = 1'b1;
    #1 check({tag, "_mdr"}, {16'h0, bus_out_m}, {16'h0, exp});
    mdr_out = 1'b0;
    #1 check({tag, "_gated"}, {16'h0, bus_out_m}, 32'h0);
  endtask

  // Issue one request at edge 0, then over a fixed 30-cycle window:
  // at cycle 1 switch ram_address/bus_in to a_after/d_after and pulse the
  // poke requests (lands while busy); optionally assert rst at cycle rst_at.
  // Records the cycle of the first done per instance and the main done count.
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [15:0] d, input logic [7:0] a_after,
                       input logic [15:0] d_after, input logic poke_rd,
                       input logic poke_wr, input int rst_at);
    @(negedge clk);
    rd_req = rd; wr_req = wr; ram_address = a; bus_in = d;
    @(posedge clk);
    lat_m = -1; lat_0 = -1; lat_4 = -1; ndone = 0; busy_rst = 1'bx;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        rd_req = poke_rd; wr_req = poke_wr; ram_address = a_after; bus_in = d_after;
      end
      if (n == 2) begin
        rd_req = 1'b0; wr_req = 1'b0;
      end
      if (rst_at > 0 && n == rst_at) rst = 1'b1;
      if (rst_at > 0 && n == rst_at + 1) begin
        rst = 1'b0;
        busy_rst = busy_m;
      end
      if (done_m) ndone++;
      if (done_m && lat_m < 0) lat_m = n;
      if (done_0 && lat_0 < 0) lat_0 = n;
      if (done_4 && lat_4 < 0) lat_4 = n;
    end
  endtask

  initial begin
    rst = 1'b1; ram_address = 8'h00; rd_req = 1'b0; wr_req = 1'b0;
    bus_in = 16'h0; mdr_out = 1'b1;
`ifdef HMMM_RAM_LOADER_EN
    load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy_m", {31'h0, busy_m}, 32'h0);
    check("rst_done_m", {31'h0, done_m}, 32'h0);
    check("rst_bus_m",  {16'h0, bus_out_m}, 32'h0);
    check("rst_idle_w0", {15'h0, busy_0, done_0, bus_out_0}, 32'h0);
    check("rst_idle_w4", {15'h0, busy_4, done_4, bus_out_4}, 32'h0);
    mdr_out = 1'b0;

    // Write 0xBEEF to 0x2A, then read back.
    do_op(1'b0, 1'b1, 8'h2A, 16'hBEEF, 8'h2A, 16'h0000, 1'b0, 1'b0, 0);
    check("wr_lat", lat_m, 3);
    check("wr_ndone", ndone, 1);
    chk_mdr("wr_no_mdr", 16'h0000);
    do_op(1'b1, 1'b0, 8'h2A, 16'h0000, 8'h2A, 16'h0000, 1'b0, 1'b0, 0);
    check("rd_lat_w1", lat_m, 3);
    check("rd_lat_w0", lat_0, 2);
    check("rd_lat_w4", lat_4, 6);
    chk_mdr("rd_2a", 16'hBEEF);

    // Read request while busy with a write to 0x05 is dropped.
    do_op(1'b0, 1'b1, 8'h05, 16'h0505, 8'h05, 16'h0000, 1'b1, 1'b0, 0);
    check("busy_rd_ndone", ndone, 1);
    chk_mdr("busy_rd_mdr", 16'hBEEF);
    do_op(1'b1, 1'b0, 8'h05, 16'h0000, 8'h05, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("rd_05", 16'h0505);

    // Write 0x1234 to 0x06 while busy is dropped; the read's address is
    // held even though ram_address moves to 0x06 mid-access.
    do_op(1'b0, 1'b1, 8'h06, 16'h6666, 8'h06, 16'h0000, 1'b0, 1'b0, 0);
    do_op(1'b1, 1'b0, 8'h05, 16'h0000, 8'h06, 16'h1234, 1'b0, 1'b1, 0);
    check("busy_wr_ndone", ndone, 1);
    chk_mdr("held_05", 16'h0505);
    do_op(1'b1, 1'b0, 8'h06, 16'h0000, 8'h06, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("rd_06", 16'h6666);

    // rd_req+wr_req together is a write; MDR untouched. bus_in changes
    // after the request edge must not leak in.
    do_op(1'b1, 1'b1, 8'hFF, 16'h00A5, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 0);
    check("both_ndone", ndone, 1);
    chk_mdr("both_mdr", 16'h6666);
    do_op(1'b1, 1'b0, 8'hFF, 16'h0000, 8'hFF, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("rd_ff", 16'h00A5);

    // Address held across WAIT.
    do_op(1'b0, 1'b1, 8'h10, 16'h1010, 8'h10, 16'h0000, 1'b0, 1'b0, 0);
    do_op(1'b0, 1'b1, 8'h20, 16'h2020, 8'h20, 16'h0000, 1'b0, 1'b0, 0);
    do_op(1'b1, 1'b0, 8'h10, 16'h0000, 8'h20, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("held_10", 16'h1010);

    // Reset during WAIT and on the ACCESS edge of writes to 0x40.
    do_op(1'b0, 1'b1, 8'h40, 16'h4444, 8'h40, 16'h0000, 1'b0, 1'b0, 0);
    do_op(1'b0, 1'b1, 8'h40, 16'h7777, 8'h40, 16'h0000, 1'b0, 1'b0, 1);
    check("rstw_ndone", ndone, 0);
    check("rstw_busy", {31'h0, busy_rst}, 32'h0);
    chk_mdr("rstw_mdr", 16'h0000);
    do_op(1'b1, 1'b0, 8'h40, 16'h0000, 8'h40, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("rstw_rd40", 16'h4444);
    do_op(1'b0, 1'b1, 8'h40, 16'h5A5A, 8'h40, 16'h0000, 1'b0, 1'b0, 2);
    check("rsta_ndone", ndone, 0);
    do_op(1'b1, 1'b0, 8'h40, 16'h0000, 8'h40, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("rsta_rd40", 16'h4444);

`ifdef HMMM_RAM_LOADER_EN
    // Preload 0x00..0x02 with a read request during load_en=1 (ignored).
    ndone = 0;
    busy_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_m) ndone++;
      busy_rst = busy_rst | busy_m;
      load_en = 1'b1; load_addr = 8'(i); load_data = 16'(i + 1);
      rd_req = (i == 1); ram_address = 8'h00;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_en = 1'b0; rd_req = 1'b0;
      if (done_m) ndone++;
      busy_rst = busy_rst | busy_m;
    end
    check("ld_ndone", ndone, 0);
    check("ld_busy", {31'h0, busy_rst}, 32'h0);
    do_op(1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("ld_rd00", 16'h0001);
    do_op(1'b1, 1'b0, 8'h01, 16'h0000, 8'h01, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("ld_rd01", 16'h0002);
    do_op(1'b1, 1'b0, 8'h02, 16'h0000, 8'h02, 16'h0000, 1'b0, 1'b0, 0);
    chk_mdr("ld_rd02", 16'h0003);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_unit.md
Name: ram_unit

Overview:
Main-memory stage of the Hmmm datapath, directly downstream of the memory address register.
- Consumes the registered 8-bit RAM address and performs word reads and writes on a 256 x 16 array.
- Inserts a configurable number of wait states per access.
- Holds read data in a memory data register (MDR) that the control unit gates onto the shared bus.

Parameters:
ADDR_W, 8, address width; the array holds 2^ADDR_W words
DATA_W, 16, word width, equal to the Hmmm instruction/data width
WAIT_CYCLES, 1, wait states per access (0..15 legal)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
ram_address  input  ADDR_W  word address, driven from the MAR output
rd_req  input  1  one-cycle read request; honoured only in IDLE
wr_req  input  1  one-cycle write request; honoured only in IDLE
bus_in  input  DATA_W  write data from the shared bus
mdr_out  input  1  drive the MDR onto bus_out
bus_out  output  DATA_W  MDR when mdr_out=1, else 0
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: clk clocks everything; reset rst is synchronous, active-high.
- Reset values: state=IDLE, MDR=0, wait counter=0, busy=0, done=0, bus_out=0.
- Reset does not clear array contents.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE, request sampled at edge t:
  - Capture ram_address, op type and bus_in into request registers; later changes to these inputs do not affect the access.
  - Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to ACCESS.
- WAIT: decrement the counter each cycle; at counter==0 go to ACCESS.
- ACCESS, at the next edge:
  - Write: array[addr] <= data.
  - Read: MDR <= array[addr].
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency: request at edge t gives done high in cycle t+2+WAIT_CYCLES (counting cycles from edge t).
  - Read data is valid in the MDR in that same cycle and holds until the next completed read or reset.
- Throughput: a new request is accepted no earlier than the first IDLE cycle after DONE.
- rd_req or wr_req asserted while busy=1 is ignored (no queueing, no error).
- rd_req and wr_req together in IDLE: treated as a write; the MDR is unchanged.
- A write does not modify the MDR.
- Read-after-write to the same address returns the new data.
- Address space is the full 2^ADDR_W words, so no out-of-range or wrap case exists.
- bus_out is purely combinational on mdr_out and the MDR.
- rst mid-access (WAIT/ACCESS/DONE) returns to IDLE on that edge:
  - A write whose ACCESS edge coincides with rst is not performed.
  - No done pulse is produced.
  - Writes completed before reset are retained.

Optional Feature:
HMMM_RAM_LOADER_EN
- Defined: adds ports load_en (in, 1), load_addr (in, ADDR_W) and load_data (in, DATA_W), used to preload programs.
  - While load_en=1, each edge writes array[load_addr] <= load_data, regardless of FSM state.
  - rd_req/wr_req are ignored while load_en=1.
  - An access already in flight continues.
  - If a load and an ACCESS-edge write hit the same address on the same edge, the load wins.
- Undefined: none of these ports exist; behaviour is exactly as above.

Decomposition:
- Shared package hmmm_pkg: ADDR_W/DATA_W defaults, FSM state encoding (typedef ram_state_t), WAIT_CYCLES maximum constant.
- Sub-module ram_array: 2^ADDR_W x DATA_W storage with one synchronous write port and one combinational read port, no reset.
- FSM, counter, request registers and MDR stay in ram_unit.

Test Plan:
- WAIT_CYCLES=1: write 0xBEEF to 0x2A at edge 0, then read 0x2A → done in cycle 3 for each op; MDR=0xBEEF; bus_out=0xBEEF only while mdr_out=1, else 0x0000.
- Ignore while busy: rd_req to 0x05 while busy after a write to 0x05 → no second done; MDR unchanged.
- Ignore while busy (write): wr_req 0x1234 to 0x06 while busy → array[0x06] unchanged.
- Simultaneous rd_req+wr_req, addr 0xFF, bus_in 0x00A5 → array[0xFF]=0x00A5; MDR keeps its prior value.
- Address held: change ram_address from 0x10 to 0x20 during WAIT of a read → MDR gets array[0x10].
- Reset mid-access: rst in WAIT of a write of 0x7777 to 0x40 → array[0x40] unchanged; busy=0 and done never pulses; a later read of 0x40 returns the old value.
- WAIT_CYCLES=0 and WAIT_CYCLES=4: done observed in cycle 2 and cycle 6 respectively after the request edge.
- With HMMM_RAM_LOADER_EN: load 0x0001..0x0003 into 0x00..0x02 → reads return those values; rd_req during load_en=1 produces no done.
